// File: rtl/id_queue_pkg.sv
// rtl/id_queue_pkg.sv - shared decode-entry width and field slice constants for IF, id_queue and ID
package id_queue_pkg;

    localparam int DECODE_ENTRY_SIZE = 96;

    localparam int ENT_CIA_HI   = 95;
    localparam int ENT_CIA_LO   = 64;
    localparam int ENT_PCA_HI   = 63;
    localparam int ENT_PCA_LO   = 32;
    localparam int ENT_INSTR_HI = 31;
    localparam int ENT_INSTR_LO = 0;

endpackage

// File: rtl/id_queue_ram.sv
// rtl/id_queue_ram.sv - entry storage, one synchronous write port and one asynchronous read port
module id_queue_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 96
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; the control logic decides which slots are live.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/id_queue.sv
// rtl/id_queue.sv - first-word-fall-through decode queue between fetch and decode
module id_queue
    import id_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          flush_fCOM,
    input  logic                          mispredict,
    input  logic                          do_write_IDQUEUE,
    input  logic [DECODE_ENTRY_SIZE-1:0]  decode_entry,
    input  logic                          do_read_IDQUEUE,
    output logic [DECODE_ENTRY_SIZE-1:0]  entry_out,
    output logic                          valid_out,
    output logic                          full_IDQUEUE,
    output logic                          almost_full_IDQUEUE,
    output logic [$clog2(DEPTH):0]        count_IDQUEUE
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_LEVEL);

    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             count;
    logic [DECODE_ENTRY_SIZE-1:0] head_entry;

    logic clear;
    logic empty;
    logic full;
    logic rd_acc;
    logic wr_acc;

    // A flush or mispredict wins over everything else in the same cycle.
    assign clear  = flush_fCOM | mispredict;
    assign empty  = (count == '0);
    assign full   = (count == CNT_FULL);
    assign rd_acc = do_read_IDQUEUE & ~empty & ~clear;
    // A full queue still takes a write when the head leaves in the same cycle.
    assign wr_acc = do_write_IDQUEUE & (~full | rd_acc) & ~clear;

    id_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DECODE_ENTRY_SIZE)
    ) u_ram (
        .CLK   (CLK),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (decode_entry),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Outputs depend only on state, so an async reset zeroes them at once.
    always_comb begin
        entry_out           = '0;
        valid_out           = ~empty;
        full_IDQUEUE        = full;
        almost_full_IDQUEUE = (count >= CNT_AFULL);
        count_IDQUEUE       = count;
        if (!empty) begin
            entry_out = head_entry;
        end
    end

endmodule
